// File: rtl/led_scan_controller_if.sv
// Display RAM read port between the scan controller and the LED RAM.
// master: drives read_address, receives read_data; slave: the RAM side.
interface led_scan_controller_if;
  logic [2:0] read_address;
  logic [7:0] read_data;

  modport master (
    output read_address,
    input  read_data
  );

  modport slave (
    input  read_address,
    output read_data
  );
endinterface

// File: rtl/led_scan_controller.sv
// Time-multiplexed LED scan sequencer: walks the display RAM digit by digit,
// inserts a dark gap before each digit and latches the segment byte.
// Ports: clk, reset (sync, active-high), scan_en, digit_mask[7:0],
//   ram (read port, master), digit_sel[7:0], seg_out[7:0], frame_done.
module led_scan_controller #(
  parameter int NUM_DIGITS = 8,
  parameter int DWELL      = 50000,
  parameter int BLANK      = 16,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scan_en,
  input  logic [7:0] digit_mask,
  led_scan_controller_if.master ram,
  output logic [7:0] digit_sel,
  output logic [7:0] seg_out,
  output logic       frame_done
);

  localparam int MAXC = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int CW   = $clog2(MAXC + 1);

  localparam logic [CW-1:0] BLANK_LD = CW'(BLANK - 1);
  localparam logic [CW-1:0] DWELL_LD = CW'(DWELL - 1);
  localparam logic [2:0]    LAST     = 3'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {
    S_OFF,
    S_BLANK,
    S_SHOW
  } state_t;

  state_t        state;
  logic [2:0]    idx;
  logic [CW-1:0] cnt;
  logic [7:0]    seg_reg;
  logic [7:0]    sel_i;
  logic [7:0]    seg_i;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_OFF;
      idx        <= 3'd0;
      cnt        <= '0;
      seg_reg    <= 8'h00;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      unique case (state)
        S_OFF: begin
          if (scan_en) begin
            state <= S_BLANK;
            idx   <= 3'd0;
            cnt   <= BLANK_LD;
          end
        end
        S_BLANK: begin
          if (!scan_en) begin
            state <= S_OFF;
            idx   <= 3'd0;
          end else if (cnt == '0) begin
            // RAM sampled once per visit so writes during SHOW
            // cannot disturb the lit pattern.
            seg_reg <= digit_mask[idx] ? ram.read_data : 8'h00;
            state   <= S_SHOW;
            cnt     <= DWELL_LD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_SHOW: begin
          if (!scan_en) begin
            state <= S_OFF;
            idx   <= 3'd0;
          end else if (cnt == '0) begin
            state <= S_BLANK;
            cnt   <= BLANK_LD;
            if (idx == LAST) begin
              idx        <= 3'd0;
              frame_done <= 1'b1;
            end else begin
              idx <= idx + 3'd1;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= S_OFF;
      endcase
    end
  end

  assign ram.read_address = idx;

  assign sel_i = (state == S_SHOW) ? (8'd1 << idx) : 8'h00;
  assign seg_i = (state == S_SHOW) ? seg_reg : 8'h00;

  // Inversion only at the pins; internal logic stays active-high.
  assign digit_sel = ACTIVE_LOW ? ~sel_i : sel_i;
  assign seg_out   = ACTIVE_LOW ? ~seg_i : seg_i;

endmodule

// File: tb/tb_led_scan_controller.sv
// Directed testbench for led_scan_controller (4 digits, DWELL=3, BLANK=2),
// plus an ACTIVE_LOW=1 instance for output polarity.
module tb_led_scan_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic       scan_en;
  logic       scan_en2;
  logic [7:0] digit_mask;
  logic [7:0] digit_sel, seg_out;
  logic       frame_done;
  logic [7:0] digit_sel2, seg_out2;
  logic       frame_done2;
  logic [7:0] ram [8];

  int checks = 0;
  int errors = 0;

  led_scan_controller_if bus ();
  led_scan_controller_if bus2 ();

  assign bus.read_data  = ram[bus.read_address];
  assign bus2.read_data = ram[bus2.read_address];

  always #5 clk = ~clk;

  led_scan_controller #(
    .NUM_DIGITS(4), .DWELL(3), .BLANK(2), .ACTIVE_LOW(1'b0)
  ) dut (
    .clk(clk), .reset(reset), .scan_en(scan_en),
    .digit_mask(digit_mask), .ram(bus.master),
    .digit_sel(digit_sel), .seg_out(seg_out), .frame_done(frame_done)
  );

  led_scan_controller #(
    .NUM_DIGITS(4), .DWELL(3), .BLANK(2), .ACTIVE_LOW(1'b1)
  ) dut_n (
    .clk(clk), .reset(reset), .scan_en(scan_en2),
    .digit_mask(digit_mask), .ram(bus2.master),
    .digit_sel(digit_sel2), .seg_out(seg_out2), .frame_done(frame_done2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves dut in cycle 1 of a fresh scan (first BLANK cycle).
  task automatic restart();
    scan_en = 1'b0;
    tick();
    tick();
    scan_en = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    checks++;
    if (digit_sel !== 8'h00 || seg_out !== 8'h00 || frame_done !== 1'b0 ||
        bus.read_address !== 3'd0) begin
      errors++;
      $display("FAIL reset_init sel=%h seg=%h fd=%b ra=%0d want 00 00 0 0",
               digit_sel, seg_out, frame_done, bus.read_address);
    end
    checks++;
    if (digit_sel2 !== 8'hFF || seg_out2 !== 8'hFF) begin
      errors++;
      $display("FAIL reset_low sel=%h seg=%h want FF FF", digit_sel2, seg_out2);
    end
    // reset mid-SHOW of digit 0
    restart();
    tick();
    tick();
    checks++;
    if (digit_sel !== 8'h01) begin
      errors++;
      $display("FAIL reset_pre_show sel=%h want 01", digit_sel);
    end
    reset = 1'b1;
    tick();
    checks++;
    if (digit_sel !== 8'h00 || seg_out !== 8'h00 || frame_done !== 1'b0 ||
        bus.read_address !== 3'd0) begin
      errors++;
      $display("FAIL reset_mid sel=%h seg=%h fd=%b ra=%0d want 00 00 0 0",
               digit_sel, seg_out, frame_done, bus.read_address);
    end
    scan_en = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    checks++;
    if (digit_sel !== 8'h00 || seg_out !== 8'h00) begin
      errors++;
      $display("FAIL reset_off sel=%h seg=%h want 00 00", digit_sel, seg_out);
    end
  endtask

  task automatic test_scan();
    logic [7:0] pat [4];
    logic [7:0] esel, eseg;
    logic       efd;
    int p, d;
    pat = '{8'h3F, 8'h06, 8'h5B, 8'h4F};
    digit_mask = 8'hFF;
    restart();
    for (int c = 1; c <= 42; c++) begin
      if (c > 1) tick();
      p    = (c - 1) % 5;
      d    = ((c - 1) / 5) % 4;
      esel = (p >= 2) ? (8'd1 << d) : 8'h00;
      eseg = (p >= 2) ? pat[d] : 8'h00;
      efd  = (c >= 21) && ((c - 21) % 20 == 0);
      checks++;
      if (digit_sel !== esel || seg_out !== eseg || frame_done !== efd) begin
        errors++;
        $display("FAIL scan c=%0d sel=%h seg=%h fd=%b want %h %h %b",
                 c, digit_sel, seg_out, frame_done, esel, eseg, efd);
      end
      if (p == 1) begin
        checks++;
        if (bus.read_address !== 3'(d)) begin
          errors++;
          $display("FAIL scan_addr c=%0d ra=%0d want %0d",
                   c, bus.read_address, d);
        end
      end
    end
  endtask

  task automatic test_coherency();
    restart();
    for (int c = 2; c <= 9; c++) tick();
    ram[1] = 8'h7F;
    checks++;
    if (digit_sel !== 8'h02 || seg_out !== 8'h06) begin
      errors++;
      $display("FAIL coh_c9 sel=%h seg=%h want 02 06", digit_sel, seg_out);
    end
    tick();
    checks++;
    if (seg_out !== 8'h06) begin
      errors++;
      $display("FAIL coh_c10 seg=%h want 06", seg_out);
    end
    for (int c = 11; c <= 28; c++) tick();
    checks++;
    if (digit_sel !== 8'h02 || seg_out !== 8'h7F) begin
      errors++;
      $display("FAIL coh_next sel=%h seg=%h want 02 7F", digit_sel, seg_out);
    end
    ram[1] = 8'h06;
  endtask

  task automatic test_mask();
    digit_mask = 8'h0B;
    restart();
    for (int c = 2; c <= 3; c++) tick();
    checks++;
    if (digit_sel !== 8'h01 || seg_out !== 8'h3F) begin
      errors++;
      $display("FAIL mask_d0 sel=%h seg=%h want 01 3F", digit_sel, seg_out);
    end
    for (int c = 4; c <= 14; c++) tick();
    checks++;
    if (digit_sel !== 8'h04 || seg_out !== 8'h00) begin
      errors++;
      $display("FAIL mask_d2 sel=%h seg=%h want 04 00", digit_sel, seg_out);
    end
    for (int c = 15; c <= 19; c++) tick();
    checks++;
    if (digit_sel !== 8'h08 || seg_out !== 8'h4F) begin
      errors++;
      $display("FAIL mask_d3 sel=%h seg=%h want 08 4F", digit_sel, seg_out);
    end
    digit_mask = 8'hFF;
  endtask

  task automatic test_disable();
    restart();
    for (int c = 2; c <= 13; c++) tick();
    checks++;
    if (digit_sel !== 8'h04 || seg_out !== 8'h5B) begin
      errors++;
      $display("FAIL dis_pre sel=%h seg=%h want 04 5B", digit_sel, seg_out);
    end
    scan_en = 1'b0;
    tick();
    checks++;
    if (digit_sel !== 8'h00 || seg_out !== 8'h00 ||
        bus.read_address !== 3'd0 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL dis_off sel=%h seg=%h ra=%0d fd=%b want 00 00 0 0",
               digit_sel, seg_out, bus.read_address, frame_done);
    end
    scan_en = 1'b1;
    tick();
    tick();
    checks++;
    if (digit_sel !== 8'h00) begin
      errors++;
      $display("FAIL dis_blank sel=%h want 00", digit_sel);
    end
    tick();
    checks++;
    if (digit_sel !== 8'h01 || seg_out !== 8'h3F) begin
      errors++;
      $display("FAIL dis_restart sel=%h seg=%h want 01 3F", digit_sel, seg_out);
    end
    scan_en = 1'b0;
    tick();
  endtask

  task automatic test_polarity();
    scan_en2 = 1'b1;
    tick();
    checks++;
    if (digit_sel2 !== 8'hFF || seg_out2 !== 8'hFF) begin
      errors++;
      $display("FAIL pol_blank sel=%h seg=%h want FF FF", digit_sel2, seg_out2);
    end
    tick();
    tick();
    checks++;
    if (digit_sel2 !== 8'hFE || seg_out2 !== 8'hC0) begin
      errors++;
      $display("FAIL pol_lit sel=%h seg=%h want FE C0", digit_sel2, seg_out2);
    end
    scan_en2 = 1'b0;
    tick();
  endtask

  initial begin
    reset      = 1'b1;
    scan_en    = 1'b0;
    scan_en2   = 1'b0;
    digit_mask = 8'hFF;
    for (int i = 0; i < 8; i++) ram[i] = 8'h00;
    ram[0] = 8'h3F;
    ram[1] = 8'h06;
    ram[2] = 8'h5B;
    ram[3] = 8'h4F;
    test_reset();
    test_scan();
    test_coherency();
    test_mask();
    test_disable();
    test_polarity();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
